// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with a line synchroniser, start-glitch
// rejection, bit-centre sampling, framing check and a per-byte LED toggle.
module uart_byte_rx #(
    parameter int MCNT_BAUD = 5208 - 1,
    parameter int MCNT_HALF = 2604 - 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       uart_rx,
    output logic [7:0] Data,
    output logic       Rx_Done,
    output logic       Frame_Err,
    output logic       Busy,
    output logic       LED
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [12:0] BAUD_END = 13'(MCNT_BAUD);
    localparam logic [12:0] HALF_END = 13'(MCNT_HALF);

    logic        s1, s2, s3;
    logic        fall;
    logic [1:0]  state;
    logic [12:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        stop_taken;
    logic        stop_bit;

    // Line idles high, so the synchroniser resets high to avoid a false start edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the previous stage's old value.
            s1 <= uart_rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;
    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            stop_taken <= 1'b0;
            stop_bit   <= 1'b0;
            Data       <= '0;
            Rx_Done    <= 1'b0;
            Frame_Err  <= 1'b0;
            LED        <= 1'b1;
        end else begin
            Rx_Done   <= 1'b0;
            Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    bit_idx    <= '0;
                    stop_taken <= 1'b0;
                    if (fall) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        // A line already back high at mid-start-bit was a glitch.
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= s2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (cnt == BAUD_END) begin
                        cnt     <= '0;
                        shift   <= {s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                STOP: begin
                    // Sample mid-stop-bit, report on the following edge, and return to IDLE
                    // without waiting for the stop bit to end so a prompt next start is caught.
                    if (stop_taken) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        stop_taken <= 1'b0;
                        if (stop_bit) begin
                            Data    <= shift;
                            Rx_Done <= 1'b1;
                            LED     <= ~LED;
                        end else begin
                            Frame_Err <= 1'b1;
                        end
                    end else if (cnt == BAUD_END) begin
                        stop_bit   <= s2;
                        stop_taken <= 1'b1;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

- Receives 8N1 UART bytes at 9600 baud from a 50 MHz clock and presents each good byte with a one-cycle strobe.
- Sits directly downstream of the UART byte transmitter, on the serial line it drives; tx-to-rx loopback is the reference system test.
- Synchronises the asynchronous line, detects the start edge and rejects glitches.
- Samples every bit at its centre, flags framing errors and toggles an LED per good byte.

## Interface
- MCNT_BAUD, 5208-1: clock cycles per bit minus one (50_000_000/9600).
- MCNT_HALF, 2604-1: cycles from start-bit entry to start-bit centre, minus one.
- CLK  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset; one clock domain only.
- uart_rx  in  1  asynchronous serial line; idle high.
- Data  out  8  last correctly received byte, LSB received first.
- Rx_Done  out  1  one-cycle pulse: Data has just been updated with a good byte.
- Frame_Err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- Busy  out  1  high while a frame is being received (state != IDLE).
- LED  out  1  toggles on every Rx_Done.

## Operation
- Input path: two-flop synchroniser s1→s2, then delay flop s3. All three reset to 1. Falling edge = s3 & ~s2.
- Counters:
  - 13-bit baud counter; reset 0; counts only in non-IDLE states.
  - 3-bit bit index.
  - 8-bit shift register; bits enter at the MSB and shift right, so the LSB-first order is restored.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Falling edge → START, with counter at 0.
  - No falling edge → stay.
- START: increment counter. At counter==MCNT_HALF, sample s2:
  - s2 = 0 → DATA, counter 0, bit index 0.
  - s2 = 1 → glitch; return to IDLE with no output pulse.
- DATA:
  - At counter==MCNT_BAUD: sample s2 into the shift register, counter 0, bit index +1.
  - After the 8th sample (bit index 7) → STOP.
- STOP: at counter==MCNT_BAUD, sample s2, then go to IDLE the next cycle. The receiver does not wait for the end of the stop bit, so a following start edge is caught.
  - s2 = 1: Data ← shift register, Rx_Done = 1 for one cycle, LED inverted.
  - s2 = 0: Frame_Err = 1 for one cycle; Data and LED unchanged.
- Break condition (line held low): no new frame starts until the line has gone high and then fallen again.
- Counter width: 13 bits covers MCNT_BAUD up to 8191. Comparisons are equality only; the counter never wraps past MCNT_BAUD.

## Timing
- Reset values: Data=0x00, Rx_Done=0, Frame_Err=0, Busy=0, LED=1, state=IDLE, all counters 0.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial byte is lost; no pulse.
- Pin-to-START latency: 3 rising edges after uart_rx falls (s1, s2, state register). Busy rises on the 3rd edge.
- From START entry:
  - Start-bit sample at cycle MCNT_HALF+1 = 2604.
  - Data bit k sampled 2604 + (k+1)·5208 cycles after START entry (k = 0..7).
  - Stop sample at 2604 + 9·5208 = 49476.
- Rx_Done / Frame_Err / new Data / LED change are all registered on the edge after the stop sample. Busy falls on that same edge.
- Rx_Done and Frame_Err are never high in the same cycle. Each pulse is exactly one cycle wide.
- Sampling point sits at bit centre ±1 cycle. The block tolerates ±4% cumulative baud mismatch over a frame.
- Back-to-back frames:
  - The next start edge may arrive anywhere from half a bit after the stop sample onward; it is detected in IDLE.
  - A falling edge during the STOP-sample cycle itself is not possible with a legal 1-stop-bit sender.

## Test plan
- Single frame 0x55, ideal 5208-cycle bits, 10 µs idle before → one Rx_Done pulse 49477 cycles after START entry; Data=0x55; LED 1→0; Frame_Err never high.
- Back-to-back 0xA3 then 0x0F, stop bit exactly one bit long, no idle gap → two Rx_Done pulses 52080 cycles apart; Data=0xA3 then 0x0F; LED ends at 1.
- Glitch: uart_rx low for 1000 cycles, then high → Busy high for ~2604 cycles then low; no Rx_Done, no Frame_Err; Data unchanged.
- Framing error: 0xFF with stop bit driven low, following good frame 0x3C → one Frame_Err pulse with Data still at its previous value and LED unchanged. Then the line idles high for one bit, and 0x3C is received correctly.
- Reset mid-frame: assert Reset during data bit 4 of 0x81 for 10 cycles, release with the line idle high, then send 0x7E → no pulse for 0x81; all outputs at reset values after assertion; 0x7E received with one Rx_Done.
- Baud skew: frames of 0xC6 at bit periods of 5000 and 5416 cycles (±4%) → Data=0xC6 each time, no Frame_Err.
